// File: rtl/imem_axil_rsp.sv
// AXI4-Lite read-only instruction memory: word-addressed synchronous RAM,
// one-deep read pipeline stage and a 3-entry in-order response FIFO.
module imem_axil_rsp #(
    parameter int               XLEN      = 32,
    parameter int               DEPTH     = 4096,
    parameter logic [XLEN-1:0]  BASE_ADDR = '0
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    input  logic [XLEN-1:0]          ARADDR,
    input  logic [2:0]               ARPROT,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [XLEN-1:0]          RDATA,
    output logic [1:0]               RRESP,
    input  logic                     load_we,
    input  logic [$clog2(DEPTH)-1:0] load_idx,
    input  logic [XLEN-1:0]          load_data
);
    localparam int             IDXW        = $clog2(DEPTH);
    localparam logic [XLEN:0]  LIMIT       = (XLEN+1)'(DEPTH * 4);
    localparam logic [1:0]     RESP_OKAY   = 2'b00;
    localparam logic [1:0]     RESP_SLVERR = 2'b10;

    logic [XLEN-1:0] mem [DEPTH];
    logic [XLEN-1:0] ram_q;

    logic            arready_reg;
    logic            p_valid_reg, p_err_reg;
    logic [XLEN-1:0] fifo_data_reg [3];
    logic [1:0]      fifo_resp_reg [3];
    logic [1:0]      wr_ptr_reg, rd_ptr_reg, count_reg;

    logic            accept, ar_err, push, pop;
    logic [XLEN-1:0] off, push_data;
    logic [1:0]      push_resp, count_next;
    logic [2:0]      occ_next;
    logic [IDXW-1:0] rd_idx;
    logic            unused_prot;

    assign accept = ARVALID && arready_reg;
    assign off    = ARADDR - BASE_ADDR;
    assign rd_idx = off[IDXW+1:2];
    // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
    assign ar_err = (ARADDR[1:0] != 2'b00) || ({1'b0, off} >= LIMIT);
    assign unused_prot = ^ARPROT;

    assign push      = p_valid_reg;
    assign pop       = (count_reg != 2'd0) && RREADY;
    assign push_data = p_err_reg ? '0 : ram_q;
    assign push_resp = p_err_reg ? RESP_SLVERR : RESP_OKAY;

    always_comb begin
        count_next = count_reg + 2'(push) - 2'(pop);
        occ_next   = 3'(accept) + 3'(count_next);
    end

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // RAM has no reset; a same-edge load and read returns the old word.
    always_ff @(posedge ACLK) begin
        if (load_we)
            mem[load_idx] <= load_data;
        if (accept)
            ram_q <= mem[rd_idx];
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            arready_reg <= 1'b0;
            p_valid_reg <= 1'b0;
            p_err_reg   <= 1'b0;
            wr_ptr_reg  <= 2'd0;
            rd_ptr_reg  <= 2'd0;
            count_reg   <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                fifo_data_reg[i] <= '0;
                fifo_resp_reg[i] <= RESP_OKAY;
            end
        end else begin
            arready_reg <= (occ_next < 3'd3);
            p_valid_reg <= accept;
            p_err_reg   <= accept && ar_err;
            count_reg   <= count_next;
            if (push) begin
                fifo_data_reg[wr_ptr_reg] <= push_data;
                fifo_resp_reg[wr_ptr_reg] <= push_resp;
                wr_ptr_reg                <= ptr_inc(wr_ptr_reg);
            end
            if (pop)
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
        end
    end

    assign ARREADY = arready_reg;
    assign RVALID  = (count_reg != 2'd0);
    assign RDATA   = fifo_data_reg[rd_ptr_reg];
    assign RRESP   = fifo_resp_reg[rd_ptr_reg];

endmodule

// File: tb/tb_imem_axil_rsp.sv
// Directed bench for imem_axil_rsp: reset, latency, streaming, backpressure,
// error decode, load/read collision and mid-stream reset.
module tb_imem_axil_rsp;
    logic        ACLK, ARESETn, ARVALID, ARREADY, RVALID, RREADY, load_we;
    logic [31:0] ARADDR, RDATA, load_data;
    logic [2:0]  ARPROT;
    logic [1:0]  RRESP;
    logic [11:0] load_idx;

    int checks   = 0;
    int failures = 0;
    int acc, beat;

    logic [31:0] seq_addr [8];
    logic [31:0] exp_data [8];
    logic [1:0]  exp_resp [8];

    imem_axil_rsp dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .load_we(load_we), .load_idx(load_idx), .load_data(load_data)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Pending read plus queued responses can never exceed the FIFO depth.
    always @(negedge ACLK) begin
        if (ARESETn === 1'b1) begin
            assert (3'(dut.p_valid_reg) + 3'(dut.count_reg) <= 3'd3) else begin
                failures++;
                $error("FAIL occupancy observed=%0d limit=3",
                       3'(dut.p_valid_reg) + 3'(dut.count_reg));
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic load(input logic [11:0] idx, input logic [31:0] data);
        load_we = 1'b1; load_idx = idx; load_data = data;
        @(negedge ACLK);
        load_we = 1'b0;
    endtask

    // Issues seq_addr[0..n-1] with RREADY high and checks beats in order.
    task automatic run_seq(input int n, input string tag);
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        RREADY = 1'b1;
        while (got < n && cyc < 40) begin
            ARVALID = (sent < n);
            ARADDR  = (sent < n) ? seq_addr[sent] : 32'h0;
            if (RVALID) begin
                chk($sformatf("%s_d%0d", tag, got), RDATA, exp_data[got]);
                chk($sformatf("%s_r%0d", tag, got), 32'(RRESP), 32'(exp_resp[got]));
                got++;
            end
            if (ARVALID && ARREADY) sent++;
            @(negedge ACLK);
            cyc++;
        end
        ARVALID = 1'b0;
        chk({tag, "_cnt"}, got, n);
    endtask

    initial begin
        ARESETn = 1'b0; ARVALID = 1'b1; ARADDR = 32'h0; ARPROT = 3'b000;
        RREADY = 1'b0; load_we = 1'b0; load_idx = '0; load_data = '0;

        // Reset held with ARVALID asserted
        for (int c = 0; c < 3; c++) begin
            @(negedge ACLK);
            chk("rst_arready", 32'(ARREADY), 0);
            chk("rst_rvalid", 32'(RVALID), 0);
            chk("rst_rdata", RDATA, 32'h0);
        end
        ARESETn = 1'b1; ARVALID = 1'b0;
        @(negedge ACLK);
        chk("rel_arready", 32'(ARREADY), 1);

        // Single read with latency check
        load(12'd5, 32'h0050_0093);
        ARVALID = 1'b1; ARADDR = 32'h14; RREADY = 1'b0;
        chk("sr_arready", 32'(ARREADY), 1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        chk("sr_lat_rvalid", 32'(RVALID), 0);
        @(negedge ACLK);
        chk("sr_rvalid", 32'(RVALID), 1);
        chk("sr_rdata", RDATA, 32'h0050_0093);
        chk("sr_rresp", 32'(RRESP), 0);
        RREADY = 1'b1;
        @(negedge ACLK);
        chk("sr_popped", 32'(RVALID), 0);

        // Streaming: beat k is visible right after the edge following its accept
        for (int i = 0; i < 8; i++) load(12'(i), 32'(i * 32'h11));
        RREADY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ARVALID = (i < 8);
            ARADDR  = 32'(i * 4);
            if (i < 8) chk($sformatf("st_arready%0d", i), 32'(ARREADY), 1);
            @(negedge ACLK);
            if (i >= 1 && i <= 8) begin
                chk($sformatf("st_rvalid%0d", i), 32'(RVALID), 1);
                chk($sformatf("st_rdata%0d", i), RDATA, 32'((i - 1) * 32'h11));
            end else begin
                chk($sformatf("st_idle%0d", i), 32'(RVALID), 0);
            end
        end
        ARVALID = 1'b0;

        // Backpressure: exactly three accepted while RREADY is low
        RREADY = 1'b0; ARVALID = 1'b1; acc = 0;
        for (int c = 0; c < 6; c++) begin
            ARADDR = 32'(acc * 4);
            if (ARREADY) acc++;
            @(negedge ACLK);
        end
        chk("bp_accepted", acc, 3);
        chk("bp_arready", 32'(ARREADY), 0);
        chk("bp_rvalid", 32'(RVALID), 1);
        chk("bp_hold", RDATA, 32'h0);
        RREADY = 1'b1; beat = 0;
        for (int c = 0; c < 20 && beat < 5; c++) begin
            ARADDR = 32'(acc * 4);
            if (RVALID) begin
                chk($sformatf("bp_beat%0d", beat), RDATA, 32'(beat * 32'h11));
                beat++;
            end
            if (ARREADY) acc++;
            @(negedge ACLK);
        end
        ARVALID = 1'b0;
        chk("bp_beats", beat, 5);
        chk("bp_resumed", 32'(acc >= 5), 1);
        for (int c = 0; c < 6; c++) @(negedge ACLK);
        chk("bp_drained", 32'(RVALID), 0);

        // Error decode interleaved with OKAY reads, including the last word
        load(12'd4095, 32'hCAFE_0001);
        seq_addr[0] = 32'h2;         exp_data[0] = 32'h0;         exp_resp[0] = 2'b10;
        seq_addr[1] = 32'h4000;      exp_data[1] = 32'h0;         exp_resp[1] = 2'b10;
        seq_addr[2] = 32'h4;         exp_data[2] = 32'h11;        exp_resp[2] = 2'b00;
        seq_addr[3] = 32'hFFFF_FFFC; exp_data[3] = 32'h0;         exp_resp[3] = 2'b10;
        seq_addr[4] = 32'h3FFC;      exp_data[4] = 32'hCAFE_0001; exp_resp[4] = 2'b00;
        run_seq(5, "err");

        // Load and read of the same index on one edge returns the old word
        RREADY = 1'b0;
        chk("col_arready", 32'(ARREADY), 1);
        ARVALID = 1'b1; ARADDR = 32'hC;
        load_we = 1'b1; load_idx = 12'd3; load_data = 32'hDEAD_BEEF;
        @(negedge ACLK);
        ARVALID = 1'b0; load_we = 1'b0;
        @(negedge ACLK);
        chk("col_rvalid", 32'(RVALID), 1);
        chk("col_old", RDATA, 32'h33);
        RREADY = 1'b1;
        @(negedge ACLK);
        seq_addr[0] = 32'hC; exp_data[0] = 32'hDEAD_BEEF; exp_resp[0] = 2'b00;
        run_seq(1, "col_new");

        // Reset with three beats queued
        RREADY = 1'b0; ARVALID = 1'b1; acc = 0;
        for (int c = 0; c < 6; c++) begin
            ARADDR = 32'(acc * 4);
            if (ARREADY) acc++;
            @(negedge ACLK);
        end
        ARVALID = 1'b0;
        chk("mr_queued", 32'(RVALID), 1);
        ARESETn = 1'b0;
        #1;
        chk("mr_rvalid", 32'(RVALID), 0);
        chk("mr_arready", 32'(ARREADY), 0);
        chk("mr_rdata", RDATA, 32'h0);
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1; RREADY = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge ACLK);
            chk($sformatf("mr_stale%0d", c), 32'(RVALID), 0);
        end
        seq_addr[0] = 32'h8; exp_data[0] = 32'h22; exp_resp[0] = 2'b00;
        run_seq(1, "mr_fresh");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_axil_rsp.md
# imem_axil_rsp

Instruction-memory responder for the RV32I core: an AXI4-Lite read-only slave that serves fetch requests issued by the instruction-fetch stage. It holds a word-addressed synchronous instruction RAM and returns one 32-bit instruction per accepted read address, in order, with a 3-entry response FIFO that sustains one read per cycle and absorbs R-channel backpressure. A side load port lets the bench or boot logic preload the program image.

## Interface
- XLEN, 32, data and address width
- DEPTH, 4096, memory depth in 32-bit words (power of two)
- BASE_ADDR, 32'h0000_0000, byte address of word 0
- ACLK  in  1  clock, all logic on the rising edge
- ARESETn  in  1  reset, asynchronous, active-low
- ARVALID  in  1  read-address valid
- ARREADY  out  1  read-address ready (registered)
- ARADDR  in  XLEN  byte address of the instruction
- ARPROT  in  3  accepted and ignored
- RVALID  out  1  read-data valid
- RREADY  in  1  read-data ready
- RDATA  out  XLEN  instruction word
- RRESP  out  2  2'b00 OKAY, 2'b10 SLVERR
- load_we  in  1  preload write enable
- load_idx  in  $clog2(DEPTH)  preload word index
- load_data  in  XLEN  preload word

## Operation
- AR handshake: ARVALID && ARREADY at a rising edge.
- Decode on accept: off = ARADDR - BASE_ADDR (XLEN-bit, wraps); idx = off >> 2. Error if ARADDR[1:0] != 0 or off >= DEPTH*4 (addresses below BASE_ADDR wrap high and therefore error).
- Stage P (one-entry pipeline register p_valid, p_err): the RAM read of idx is launched on the accept edge; the RAM output is valid in the following cycle.
- On the next edge the P entry is pushed into the response FIFO as {data, resp}; an error entry pushes data 0 and resp SLVERR. A RAM read is not required for error entries.
- FIFO: 3 entries, in order. RVALID = (count != 0); RDATA/RRESP = head entry. Pop on RVALID && RREADY.
- Occupancy occ = p_valid + count. Next ARREADY = (occ_next < 3), registered. There is no combinational path from RREADY or ARVALID to ARREADY.
- Push, pop and accept may all occur on the same edge. count updates by push minus pop. Overflow cannot occur by construction; the bench asserts count <= 3.
- Load port: load_we writes mem[load_idx] at the edge. If a read of the same index is launched on the same edge, the read returns the old word (read-first).
- The RAM has no reset. Contents are undefined until loaded.

## Timing
- Reset (asynchronous assert): ARREADY=0, RVALID=0, RDATA=0, RRESP=0, p_valid=0, count=0. In-flight and queued responses are discarded.
- ARREADY rises at the first rising edge after ARESETn deasserts.
- Latency: AR accepted at edge N -> RVALID high after edge N+1 with that response; the earliest R handshake is at edge N+2.
- Throughput: with RREADY held high, one AR is accepted and one R beat completes per cycle indefinitely; ARREADY stays 1.
- Backpressure: with RREADY low, at most 3 reads are accepted beyond the last popped beat. ARREADY falls the cycle after occ reaches 3 and rises the cycle after a pop makes occ_next < 3.
- RDATA and RRESP hold stable while RVALID && !RREADY. RVALID never deasserts without a handshake, except on reset.
- Responses are returned strictly in AR acceptance order, including interleaved error and OKAY responses.

## Test plan
- Reset: hold ARESETn low 3 cycles with ARVALID=1 -> ARREADY=0, RVALID=0, RDATA=0 throughout. ARREADY=1 one edge after release.
- Single read: preload mem[5]=32'h00500093. AR 0x14 accepted at edge N -> RVALID=1 after N+1, RDATA=32'h00500093, RRESP=00.
- Streaming: preload words 0..7 = i*0x11. Issue ARADDR 0,4,...,28 back-to-back with RREADY=1 -> 8 beats on 8 consecutive cycles in order, with ARREADY continuously 1.
- Backpressure: RREADY=0 while ARVALID stays high with addresses 0,4,8,12,... -> exactly 3 accepted and ARREADY=0. Raise RREADY -> data 0x00,0x11,0x22 in order, then accepts resume.
- Errors: ARADDR 0x2 (misaligned), DEPTH*4 (out of range) and 0x4 interleaved -> RRESP SLVERR/RDATA 0, SLVERR/0, then OKAY/0x11, in order.
- Collision and reset: load_we to index 3 (new 0xDEAD_BEEF) on the same edge as the read of 0xC -> old word returned, and a subsequent read returns 0xDEAD_BEEF. Assert ARESETn mid-stream with 3 beats queued -> RVALID=0 immediately, and no stale beat appears after release.
